// File: rtl/execute_stage.sv
// execute_stage: DHRUT-V RV32I execute stage (ALU, address generation, branch/jump resolution).
// Define EXECUTE_MUL_EN to add an iterative shift-add RV32M multiplier that stalls decode while busy.
`ifndef N
`define N 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module execute_stage (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`ADDR_WIDTH-1:0] i_pc,
    input  logic [`N-1:0]          i_rs1_data,
    input  logic [`N-1:0]          i_rs2_data,
    input  logic [`N-1:0]          i_imm,
    input  logic [2:0]             i_func3,
    input  logic [6:0]             i_func7,
    input  logic [4:0]             i_rd,
    input  logic [6:0]             i_opcode,
    input  logic                   i_id_valid,
    output logic                   o_stall,
    input  logic                   i_mem_stall,
    output logic [`N-1:0]          o_result,
    output logic [`N-1:0]          o_data_store,
    output logic [`ADDR_WIDTH-1:0] o_pc,
    output logic [2:0]             o_func3,
    output logic [4:0]             o_rd,
    output logic [6:0]             o_opcode,
    output logic                   o_ex_valid,
    output logic                   o_redirect,
    output logic [`ADDR_WIDTH-1:0] o_redirect_pc
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic                   accept;
    logic                   hold;
    logic                   mul_busy;
    logic                   is_mul;
    logic [`N-1:0]          op_b;
    logic [4:0]             shamt;
    logic                   sub_sel;
    logic [`N-1:0]          alu_out;
    logic                   branch_taken;
    logic [`N-1:0]          next_result;
    logic                   next_redirect;
    logic [`ADDR_WIDTH-1:0] next_target;
    logic [`ADDR_WIDTH-1:0] pc_plus_4;
    logic [`ADDR_WIDTH-1:0] pc_plus_imm;
    logic [`ADDR_WIDTH-1:0] jalr_target;
    logic [`N-1:0]          rs1_plus_imm;

    assign hold    = o_ex_valid & i_mem_stall;
    assign o_stall = mul_busy | hold;
    // The instruction presented alongside a redirect pulse is on the wrong path and is dropped.
    assign accept  = i_id_valid & ~o_stall & ~o_redirect;

    assign op_b         = (i_opcode == OPC_OP) ? i_rs2_data : i_imm;
    assign shamt        = op_b[4:0];
    assign sub_sel      = (i_opcode == OPC_OP) & i_func7[5];
    assign pc_plus_4    = i_pc + `ADDR_WIDTH'(4);
    assign pc_plus_imm  = i_pc + i_imm;
    assign rs1_plus_imm = i_rs1_data + i_imm;
    assign jalr_target  = rs1_plus_imm & ~`ADDR_WIDTH'(1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alu_out = '0;
        case (i_func3)
            3'b000: alu_out = sub_sel ? i_rs1_data - op_b : i_rs1_data + op_b;
            3'b001: alu_out = i_rs1_data << shamt;
            3'b010: alu_out = {{(`N-1){1'b0}}, $signed(i_rs1_data) < $signed(op_b)};
            3'b011: alu_out = {{(`N-1){1'b0}}, i_rs1_data < op_b};
            3'b100: alu_out = i_rs1_data ^ op_b;
            3'b101: alu_out = i_func7[5] ? $unsigned($signed(i_rs1_data) >>> shamt)
                                         : i_rs1_data >> shamt;
            3'b110: alu_out = i_rs1_data | op_b;
            3'b111: alu_out = i_rs1_data & op_b;
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (i_func3)
            3'b000: branch_taken = (i_rs1_data == i_rs2_data);
            3'b001: branch_taken = (i_rs1_data != i_rs2_data);
            3'b100: branch_taken = ($signed(i_rs1_data) <  $signed(i_rs2_data));
            3'b101: branch_taken = ($signed(i_rs1_data) >= $signed(i_rs2_data));
            3'b110: branch_taken = (i_rs1_data <  i_rs2_data);
            3'b111: branch_taken = (i_rs1_data >= i_rs2_data);
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        next_result   = '0;
        next_redirect = 1'b0;
        next_target   = pc_plus_imm;
        case (i_opcode)
            OPC_LUI:    next_result = i_imm;
            OPC_AUIPC:  next_result = pc_plus_imm;
            OPC_JAL: begin
                next_result   = pc_plus_4;
                next_redirect = 1'b1;
            end
            OPC_JALR: begin
                next_result   = pc_plus_4;
                next_redirect = 1'b1;
                next_target   = jalr_target;
            end
            OPC_BRANCH: next_redirect = branch_taken;
            OPC_LOAD,
            OPC_STORE:  next_result = rs1_plus_imm;
            OPC_OP_IMM: next_result = alu_out;
`ifdef EXECUTE_MUL_EN
            // DIV/REM are unimplemented and retire as zero; MUL* never load from here.
            OPC_OP:     next_result = (i_func7 == 7'b0000001) ? '0 : alu_out;
`else
            OPC_OP:     next_result = alu_out;
`endif
            default:    next_result = '0;
        endcase
    end

`ifdef EXECUTE_MUL_EN
    typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;

    mul_state_t             mul_state;
    logic [2*`N-1:0]        mul_acc;
    logic [2*`N-1:0]        mul_mcand;
    logic [`N-1:0]          mul_mplier;
    logic [4:0]             mul_count;
    logic                   mul_neg;
    logic [2:0]             mul_func3;
    logic [`ADDR_WIDTH-1:0] mul_pc;
    logic [4:0]             mul_rd;
    logic [`N-1:0]          mul_rs2;
    logic                   a_neg;
    logic                   b_neg;
    logic [2*`N-1:0]        mul_product;
    logic [`N-1:0]          mul_result;

    assign is_mul   = (i_opcode == OPC_OP) & (i_func7 == 7'b0000001) & ~i_func3[2];
    assign mul_busy = (mul_state != MUL_IDLE);
    // rs1 is signed for MUL/MULH/MULHSU, rs2 only for MUL/MULH.
    assign a_neg    = (i_func3 != 3'b011) & i_rs1_data[`N-1];
    assign b_neg    = ~i_func3[1] & i_rs2_data[`N-1];
    assign mul_product = mul_neg ? -mul_acc : mul_acc;
    assign mul_result  = (mul_func3 == 3'b000) ? mul_product[`N-1:0] : mul_product[2*`N-1:`N];

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state  <= MUL_IDLE;
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_count  <= '0;
            mul_neg    <= 1'b0;
            mul_func3  <= '0;
            mul_pc     <= '0;
            mul_rd     <= '0;
            mul_rs2    <= '0;
        end else begin
            case (mul_state)
                MUL_IDLE: if (accept && is_mul) begin
                    mul_state  <= MUL_BUSY;
                    mul_acc    <= '0;
                    mul_mcand  <= {{`N{1'b0}}, a_neg ? -i_rs1_data : i_rs1_data};
                    mul_mplier <= b_neg ? -i_rs2_data : i_rs2_data;
                    mul_count  <= '0;
                    mul_neg    <= a_neg ^ b_neg;
                    mul_func3  <= i_func3;
                    mul_pc     <= i_pc;
                    mul_rd     <= i_rd;
                    mul_rs2    <= i_rs2_data;
                end
                MUL_BUSY: begin
                    if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
                    mul_mcand  <= mul_mcand << 1;
                    mul_mplier <= mul_mplier >> 1;
                    mul_count  <= mul_count + 5'd1;
                    if (mul_count == 5'd31) mul_state <= MUL_DONE;
                end
                MUL_DONE: if (!hold) mul_state <= MUL_IDLE;
                default:  mul_state <= MUL_IDLE;
            endcase
        end
    end
`else
    logic unused_func7;

    assign is_mul       = 1'b0;
    assign mul_busy     = 1'b0;
    assign unused_func7 = ^{i_func7[6], i_func7[4:0]};
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_result      <= '0;
            o_data_store  <= '0;
            o_pc          <= '0;
            o_func3       <= '0;
            o_rd          <= '0;
            o_opcode      <= '0;
            o_ex_valid    <= 1'b0;
            o_redirect    <= 1'b0;
            o_redirect_pc <= '0;
        end else if (hold) begin
            // Everything freezes except the redirect, which must pulse only once.
            o_redirect <= 1'b0;
`ifdef EXECUTE_MUL_EN
        end else if (mul_state == MUL_DONE) begin
            o_result     <= mul_result;
            o_data_store <= mul_rs2;
            o_pc         <= mul_pc;
            o_func3      <= mul_func3;
            o_rd         <= mul_rd;
            o_opcode     <= OPC_OP;
            o_ex_valid   <= 1'b1;
            o_redirect   <= 1'b0;
`endif
        end else if (accept && !is_mul) begin
            o_result      <= next_result;
            o_data_store  <= i_rs2_data;
            o_pc          <= i_pc;
            o_func3       <= i_func3;
            o_rd          <= i_rd;
            o_opcode      <= i_opcode;
            o_ex_valid    <= 1'b1;
            o_redirect    <= next_redirect;
            o_redirect_pc <= next_target;
        end else begin
            o_ex_valid <= 1'b0;
            o_redirect <= 1'b0;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push expected results, a negedge monitor
// pops and compares them whenever the pipeline register presents a valid instruction.
`ifndef N
`define N 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_pc = '0, i_rs1_data = '0, i_rs2_data = '0, i_imm = '0;
    logic [2:0]  i_func3 = '0;
    logic [6:0]  i_func7 = '0;
    logic [4:0]  i_rd = '0;
    logic [6:0]  i_opcode = '0;
    logic        i_id_valid = 1'b0;
    logic        i_mem_stall = 1'b0;
    logic        o_stall, o_ex_valid, o_redirect;
    logic [31:0] o_result, o_data_store, o_pc, o_redirect_pc;
    logic [2:0]  o_func3;
    logic [4:0]  o_rd;
    logic [6:0]  o_opcode;

    execute_stage dut (
        .clk(clk), .rst(rst), .i_pc(i_pc), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_imm(i_imm), .i_func3(i_func3), .i_func7(i_func7), .i_rd(i_rd), .i_opcode(i_opcode),
        .i_id_valid(i_id_valid), .o_stall(o_stall), .i_mem_stall(i_mem_stall),
        .o_result(o_result), .o_data_store(o_data_store), .o_pc(o_pc), .o_func3(o_func3),
        .o_rd(o_rd), .o_opcode(o_opcode), .o_ex_valid(o_ex_valid), .o_redirect(o_redirect),
        .o_redirect_pc(o_redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [31:0] store;
        logic [31:0] pc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [6:0]  op;
        logic        redirect;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   first = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: peek during a memory hold, pop when the instruction moves on.
    always @(negedge clk) begin
        if (rst) begin
            first = 1'b1;
        end else if (o_ex_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(o_ex_valid), 32'd0);
            end else begin
                mon_e = exp_q[0];
                check("result",     o_result,          mon_e.result);
                check("data_store", o_data_store,      mon_e.store);
                check("pc",         o_pc,              mon_e.pc);
                check("func3",      32'(o_func3),      32'(mon_e.f3));
                check("rd",         32'(o_rd),         32'(mon_e.rd));
                check("opcode",     32'(o_opcode),     32'(mon_e.op));
                check("redirect",   32'(o_redirect),   first ? 32'(mon_e.redirect) : 32'd0);
                if (first && mon_e.redirect) check("redirect_pc", o_redirect_pc, mon_e.rpc);
                if (i_mem_stall) begin
                    first = 1'b0;
                end else begin
                    void'(exp_q.pop_front());
                    first = 1'b1;
                end
            end
        end
    end

    task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [6:0] op);
        i_pc = pc; i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm;
        i_func3 = f3; i_func7 = f7; i_rd = rd; i_opcode = op;
        i_id_valid = 1'b1;
    endtask

    task automatic expect_out(input logic [31:0] pc, rs2, input logic [2:0] f3, input logic [4:0] rd,
                              input logic [6:0] op, input logic [31:0] res, input logic redir,
                              input logic [31:0] rpc);
        exp_t e;
        e.result = res; e.store = rs2; e.pc = pc; e.f3 = f3; e.rd = rd; e.op = op;
        e.redirect = redir; e.rpc = rpc;
        exp_q.push_back(e);
    endtask

    // Called just after a posedge; returns just after the edge that accepted the instruction.
    task automatic issue(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [6:0] op,
                         input logic [31:0] res, input logic redir, input logic [31:0] rpc);
        int n = 0;
        expect_out(pc, rs2, f3, rd, op, res, redir, rpc);
        drive(pc, rs1, rs2, imm, f3, f7, rd, op);
        @(negedge clk);
        while ((o_stall || o_redirect) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("accept_timeout", 32'({o_stall, o_redirect}), 32'd0);
        @(posedge clk); #1;
        i_id_valid = 1'b0;
    endtask

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ex_valid",   32'(o_ex_valid), 32'd0);
        check("reset_result",     o_result,        32'd0);
        check("reset_redirect",   32'(o_redirect), 32'd0);
        check("reset_stall",      32'(o_stall),    32'd0);
        check("reset_pc",         o_pc,            32'd0);
        check("reset_data_store", o_data_store,    32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ADDI with func7 bits set by the immediate: must still add.
        issue(32'h0, 32'd5, 32'd0, 32'hFFFF_FFF9, 3'b000, 7'h7F, 5'd1, OPI, 32'hFFFF_FFFE, 1'b0, 32'h0);
        @(negedge clk); check("addi_latency", 32'(o_ex_valid), 32'd1);
        @(posedge clk); #1;

        // Back-to-back ALU traffic.
        issue(32'h4,  32'd10,        32'd15,       32'h0,   3'b000, 7'h20, 5'd2, OP,  32'hFFFF_FFFB, 1'b0, 32'h0);
        issue(32'h8,  32'h8000_0000, 32'd0,        32'h404, 3'b101, 7'h20, 5'd3, OPI, 32'hF800_0000, 1'b0, 32'h0);
        issue(32'hC,  32'hFFFF_FFFF, 32'd1,        32'h0,   3'b010, 7'h00, 5'd4, OP,  32'd1,         1'b0, 32'h0);
        issue(32'h10, 32'hFFFF_FFFF, 32'd1,        32'h0,   3'b011, 7'h00, 5'd5, OP,  32'd0,         1'b0, 32'h0);
        issue(32'h14, 32'd1,         32'd0,        32'd31,  3'b001, 7'h00, 5'd6, OPI, 32'h8000_0000, 1'b0, 32'h0);
        issue(32'h18, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0,  3'b100, 7'h00, 5'd7, OP,  32'h0000_FF00, 1'b0, 32'h0);
        issue(32'h1C, 32'h8000_0000, 32'h21,       32'h0,   3'b101, 7'h00, 5'd8, OP,  32'h4000_0000, 1'b0, 32'h0);
        issue(32'h20, 32'd1,         32'd2,        32'h0,   3'b110, 7'h00, 5'd9, OP,  32'd3,         1'b0, 32'h0);
        issue(32'h24, 32'd0,         32'd0,        32'h1234_5000, 3'b000, 7'h00, 5'd10, LUI, 32'h1234_5000, 1'b0, 32'h0);
        issue(32'hFFFF_FFF0, 32'd0,  32'd0,        32'h20,  3'b000, 7'h00, 5'd11, AUIPC, 32'h0000_0010, 1'b0, 32'h0);
        issue(32'h28, 32'h1000,      32'd9,        32'hFFFF_FFFC, 3'b010, 7'h00, 5'd12, LD, 32'h0000_0FFC, 1'b0, 32'h0);
        issue(32'h2C, 32'd1,         32'd2,        32'h0,   3'b000, 7'h00, 5'd13, 7'h7F, 32'd0, 1'b0, 32'h0);

        // Taken BEQ: the instruction presented during the pulse is squashed.
        issue(32'h100, 32'd3, 32'd3, 32'h20, 3'b000, 7'h00, 5'd0, BR, 32'd0, 1'b1, 32'h120);
        drive(32'h104, 32'd1, 32'd1, 32'd1, 3'b000, 7'h00, 5'd14, OPI);
        @(negedge clk);
        check("squash_stall",    32'(o_stall),    32'd0);
        check("squash_redirect", 32'(o_redirect), 32'd1);
        @(posedge clk); #1;
        i_id_valid = 1'b0;
        @(negedge clk);
        check("squash_valid",     32'(o_ex_valid), 32'd0);
        check("redirect_one_shot", 32'(o_redirect), 32'd0);
        @(posedge clk); #1;

        issue(32'h40,  32'h1001,      32'd0, 32'd2,         3'b000, 7'h00, 5'd1, JALR, 32'h44,  1'b1, 32'h1002);
        issue(32'h80,  32'd3,         32'd3, 32'h10,        3'b001, 7'h00, 5'd0, BR,   32'd0,   1'b0, 32'h0);
        issue(32'h84,  32'hFFFF_FFFF, 32'd1, 32'h10,        3'b101, 7'h00, 5'd0, BR,   32'd0,   1'b0, 32'h0);
        issue(32'h88,  32'd2, 32'hFFFF_FFFE, 32'h10,        3'b111, 7'h00, 5'd0, BR,   32'd0,   1'b0, 32'h0);
        issue(32'h8C,  32'd4,         32'd4, 32'h10,        3'b010, 7'h00, 5'd0, BR,   32'd0,   1'b0, 32'h0);
        issue(32'h300, 32'hFFFF_FFFB, 32'd2, 32'hFFFF_FFF0, 3'b100, 7'h00, 5'd0, BR,   32'd0,   1'b1, 32'h2F0);
        issue(32'h310, 32'd1, 32'hFFFF_FFFF, 32'h8,         3'b110, 7'h00, 5'd0, BR,   32'd0,   1'b1, 32'h318);

        // JAL with a memory hold in the same cycle: one redirect pulse only.
        issue(32'h200, 32'd0, 32'd0, 32'hFFFF_FFF8, 3'b000, 7'h00, 5'd1, JAL, 32'h204, 1'b1, 32'h1F8);
        i_mem_stall = 1'b1;
        repeat (2) @(posedge clk);
        #1 i_mem_stall = 1'b0;
        @(posedge clk); #1;

        // Store held three cycles by memory; an ADD waits behind it.
        issue(32'h50, 32'h2000, 32'hDEAD_BEEF, 32'd4, 3'b010, 7'h00, 5'd0, ST, 32'h2004, 1'b0, 32'h0);
        i_mem_stall = 1'b1;
        expect_out(32'h54, 32'd1, 3'b000, 5'd15, OP, 32'h8000_0000, 1'b0, 32'h0);
        drive(32'h54, 32'h7FFF_FFFF, 32'd1, 32'd0, 3'b000, 7'h00, 5'd15, OP);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("memstall_stall",  32'(o_stall), 32'd1);
            check("memstall_result", o_result,     32'h2004);
            @(posedge clk); #1;
        end
        i_mem_stall = 1'b0;
        @(negedge clk); check("release_stall", 32'(o_stall), 32'd0);
        @(posedge clk); #1;
        i_id_valid = 1'b0;
        @(negedge clk); check("backpressure_add_valid", 32'(o_ex_valid), 32'd1);
        @(posedge clk); #1;

`ifdef EXECUTE_MUL_EN
        issue(32'h400, 32'hFFFF_FFFD, 32'd7, 32'd0, 3'b000, 7'h01, 5'd20, OP, 32'hFFFF_FFEB, 1'b0, 32'h0);
        check("mul_accept_valid", 32'(o_ex_valid), 32'd0);
        check("mul_busy_stall",   32'(o_stall),    32'd1);
        lat = 0;
        while (!o_ex_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("mul_latency", 32'(lat), 32'd33);
        @(posedge clk); #1;
        issue(32'h404, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 3'b011, 7'h01, 5'd21, OP, 32'hFFFF_FFFE, 1'b0, 32'h0);
        issue(32'h408, 32'h8000_0000, 32'h8000_0000, 32'd0, 3'b001, 7'h01, 5'd22, OP, 32'h4000_0000, 1'b0, 32'h0);
        issue(32'h40C, 32'hFFFF_FFFF, 32'd2,         32'd0, 3'b010, 7'h01, 5'd23, OP, 32'hFFFF_FFFF, 1'b0, 32'h0);
        issue(32'h410, 32'd100,       32'd7,         32'd0, 3'b100, 7'h01, 5'd24, OP, 32'd0,         1'b0, 32'h0);
        @(negedge clk); check("div_latency", 32'(o_ex_valid), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a multiply abandons it.
        issue(32'h500, 32'd6, 32'd7, 32'd0, 3'b000, 7'h01, 5'd25, OP, 32'd42, 1'b0, 32'h0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("midmul_reset_valid",  32'(o_ex_valid), 32'd0);
        check("midmul_reset_stall",  32'(o_stall),    32'd0);
        check("midmul_reset_result", o_result,        32'd0);
        check("midmul_reset_pc",     o_pc,            32'd0);
        repeat (40) @(posedge clk);
        #1;
        issue(32'h600, 32'd20, 32'd22, 32'd0, 3'b000, 7'h00, 5'd26, OP, 32'd42, 1'b0, 32'h0);
        @(negedge clk); check("post_reset_add_latency", 32'(o_ex_valid), 32'd1);
        @(posedge clk); #1;
`else
        // Without the multiplier, func7=0000001 is a plain ADD with single-cycle latency.
        issue(32'h400, 32'd6, 32'd7, 32'd0, 3'b000, 7'h01, 5'd20, OP, 32'd13, 1'b0, 32'h0);
        check("nomul_stall", 32'(o_stall), 32'd0);
        @(negedge clk); check("nomul_latency", 32'(o_ex_valid), 32'd1);
        @(posedge clk); #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage DHRUT-V RV32I pipeline, between decode and the memory stage. Performs ALU operations, address generation, and branch/jump resolution. Registers its results into the pipeline register that drives the memory stage, and raises a one-cycle redirect toward fetch. Optionally includes an iterative RV32M multiplier that holds the pipeline while busy.

## Interface
Parameters: none. Widths come from the global `` `N`` (data, 32) and `` `ADDR_WIDTH`` (32) macros.

- clk  in  1  single clock, all state on posedge
- rst  in  1  reset, synchronous, active-high
- i_pc  in  `ADDR_WIDTH  instruction PC from decode
- i_rs1_data, i_rs2_data  in  `N  register operands
- i_imm  in  `N  sign-extended immediate
- i_func3  in  3  funct3
- i_func7  in  7  funct7
- i_rd  in  5  destination register
- i_opcode  in  7  opcode
- i_id_valid  in  1  decode presents a valid instruction
- o_stall  out  1  execute cannot accept this cycle; decode holds
- i_mem_stall  in  1  memory stage not accepting
- o_result, o_data_store  out  `N  ALU result/address; store data (rs2)
- o_pc  out  `ADDR_WIDTH; o_func3 out 3; o_rd out 5; o_opcode out 7  forwarded fields
- o_ex_valid  out  1  pipeline register holds a valid instruction
- o_redirect  out  1  one-cycle pulse: taken branch or jump
- o_redirect_pc  out  `ADDR_WIDTH  redirect target

## Operation
- Accept condition: `i_id_valid && !o_stall && !o_redirect`. Accept loads the pipeline register and sets o_ex_valid=1. If there is no accept and no hold, o_ex_valid=0.
- Hold: when `o_ex_valid && i_mem_stall`, all outputs are frozen.
- o_stall = mul_busy | (o_ex_valid & i_mem_stall). This path is combinational.
- Opcodes and results:
  - LUI (0110111): imm.
  - AUIPC (0010111): pc+imm.
  - JAL (1101111): result pc+4; redirect to pc+imm.
  - JALR (1100111): result pc+4; redirect to (rs1+imm)&~1.
  - BRANCH (1100011): result 0; redirect to pc+imm if taken.
  - LOAD (0000011) / STORE (0100011): rs1+imm.
  - OP-IMM (0010011) / OP (0110011): standard ALU. func7[5] selects SUB/SRA; shifts use operand[4:0].
  - Unknown opcode: result 0, still passed with valid.
- Branch conditions, by func3:
  - 000 EQ, 001 NE
  - 100 LT, 101 GE (signed)
  - 110 LTU, 111 GEU (unsigned)
  - 010/011: never taken.
- o_data_store = rs2 for every instruction.
- Arithmetic is 32-bit modulo with no overflow flag. pc+4 and pc+imm wrap at 2^32.
- o_redirect and o_redirect_pc are registered alongside the instruction, so the pulse coincides with the jump's first o_ex_valid cycle. The instruction presented in that cycle is squashed: not captured, and o_stall stays low so decode drops it.
- If redirect and i_mem_stall occur together, o_redirect stays high for exactly one cycle; the pulse is not repeated during the hold.

## Timing
- Reset: all outputs 0, multiplier state IDLE. Reset mid-multiply abandons the operation, with no output.
- ALU, branch, and memory-address instructions: latency 1; accept at edge k gives o_ex_valid at cycle k+1. Throughput is 1/cycle when unstalled.
- Back-to-back accepts are allowed. A hold on the memory side back-pressures decode in the same cycle.

## Configuration
- `EXECUTE_MUL_EN` defined: OP with func7=0000001 and func3 000/001/010/011 runs MUL/MULH/MULHSU/MULHU.
  - FSM: IDLE, BUSY, DONE.
  - Accept (IDLE→BUSY) latches operand magnitudes, result sign, and the func3/pc/rd fields; the accept cycle shows o_ex_valid=0.
  - BUSY runs 32 shift-add iterations over a 64-bit accumulator and raises o_stall for all 32 cycles.
  - BUSY→DONE after the 32nd iteration. DONE negates the product if required, loads the pipeline register (lower or upper word) and returns to IDLE. o_ex_valid rises 33 cycles after accept.
  - If o_ex_valid && i_mem_stall in DONE, remain in DONE.
  - func3 1xx (DIV/REM): result 0, latency 1.
- Undefined: func7=0000001 decodes as the base OP (func7[5]=0). No FSM is instantiated and o_stall never asserts due to multiply.

## Test plan
- ADDI rs1=5, imm=-7 → o_result=0xFFFFFFFE, o_ex_valid one cycle after accept.
- BEQ pc=0x100, rs1=rs2=3, imm=0x20 → o_redirect=1 for one cycle, o_redirect_pc=0x120; the next presented instruction is squashed.
- JALR pc=0x40, rs1=0x1001, imm=2 → o_result=0x44, o_redirect_pc=0x1002.
- SW rs1=0x2000, imm=4, rs2=0xDEADBEEF; i_mem_stall held 3 cycles → o_result=0x2004 and o_data_store stable; o_stall=1 for 3 cycles.
- (`EXECUTE_MUL_EN`) MUL -3×7 → 0xFFFFFFEB after 33 cycles. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- (`EXECUTE_MUL_EN`) rst at BUSY cycle 10 → all outputs 0, state IDLE. A subsequent ADD completes with latency 1.
